// File: rtl/painter_clken_gen.sv
// rtl/painter_clken_gen.sv - multi-channel fractional clock-enable generator
// Optional global phase realignment input enabled by PAINTER_CLKEN_ALIGN_EN.
module painter_clken_gen #(
    parameter int NUM_CH      = 4,
    parameter int ACC_W       = 32,
    parameter int LOCK_CYCLES = 16,
    localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              refclk,
    input  logic              rst,
`ifdef PAINTER_CLKEN_ALIGN_EN
    input  logic              align,
`endif
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [ACC_W-1:0]  cfg_inc,
    input  logic [ACC_W-1:0]  cfg_phase,
    output logic              cfg_err,
    output logic [NUM_CH-1:0] outen,
    output logic [NUM_CH-1:0] ch_locked,
    output logic              locked
);

    localparam int CNT_W = $clog2(LOCK_CYCLES + 1);
    localparam logic [CNT_W-1:0] LOCK_INIT = CNT_W'(LOCK_CYCLES);

    logic [ACC_W-1:0]  r_inc [NUM_CH];
    logic [ACC_W-1:0]  r_acc [NUM_CH];
    logic [CNT_W-1:0]  r_cnt [NUM_CH];
    logic [NUM_CH-1:0] r_outen;
    logic [NUM_CH-1:0] r_ch_locked;
    logic              r_locked;
    logic              r_cfg_ready;
    logic              r_cfg_err;

    logic [ACC_W-1:0]  w_inc_nxt [NUM_CH];
    logic [ACC_W-1:0]  w_acc_nxt [NUM_CH];
    logic [CNT_W-1:0]  w_cnt_nxt [NUM_CH];
    logic [ACC_W:0]    w_sum     [NUM_CH];
    logic [NUM_CH-1:0] w_outen_nxt;
    logic [NUM_CH-1:0] w_ch_locked_nxt;
    logic              w_wr;
    logic              w_bad;

`ifdef PAINTER_CLKEN_ALIGN_EN
    logic [ACC_W-1:0]  r_phase     [NUM_CH];
    logic [ACC_W-1:0]  w_phase_nxt [NUM_CH];
`endif

    assign w_wr  = cfg_valid & r_cfg_ready;
    assign w_bad = (int'(cfg_ch) >= NUM_CH);

    // State register: a nonzero settle count means SETTLE, zero means RUN.
    always_ff @(posedge refclk) begin
        if (rst) begin
            for (int c = 0; c < NUM_CH; c++) begin
                r_inc[c] <= '0;
                r_acc[c] <= '0;
                r_cnt[c] <= LOCK_INIT;
`ifdef PAINTER_CLKEN_ALIGN_EN
                r_phase[c] <= '0;
`endif
            end
            r_outen     <= '0;
            r_ch_locked <= '0;
            r_locked    <= 1'b0;
            r_cfg_ready <= 1'b0;
            r_cfg_err   <= 1'b0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                r_inc[c] <= w_inc_nxt[c];
                r_acc[c] <= w_acc_nxt[c];
                r_cnt[c] <= w_cnt_nxt[c];
`ifdef PAINTER_CLKEN_ALIGN_EN
                r_phase[c] <= w_phase_nxt[c];
`endif
            end
            r_outen     <= w_outen_nxt;
            r_ch_locked <= w_ch_locked_nxt;
            r_locked    <= &w_ch_locked_nxt;
            r_cfg_ready <= 1'b1;
            r_cfg_err   <= w_wr & w_bad;
        end
    end

    // Next-state: settle countdown, accumulate in RUN, config write wins last.
    always_comb begin
        w_outen_nxt = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            w_sum[c]     = {1'b0, r_acc[c]} + {1'b0, r_inc[c]};
            w_inc_nxt[c] = r_inc[c];
            w_acc_nxt[c] = r_acc[c];
            w_cnt_nxt[c] = r_cnt[c];
`ifdef PAINTER_CLKEN_ALIGN_EN
            w_phase_nxt[c] = r_phase[c];
`endif
            if (r_cnt[c] != '0) begin
                w_cnt_nxt[c] = r_cnt[c] - 1'b1;
            end else begin
                w_acc_nxt[c]   = w_sum[c][ACC_W-1:0];
                w_outen_nxt[c] = w_sum[c][ACC_W];
`ifdef PAINTER_CLKEN_ALIGN_EN
                if (align) begin
                    w_acc_nxt[c]   = r_phase[c];
                    w_outen_nxt[c] = 1'b0;
                end
`endif
            end
            if (w_wr && !w_bad && (cfg_ch == CH_W'(c))) begin
                w_inc_nxt[c]   = cfg_inc;
                w_acc_nxt[c]   = cfg_phase;
                w_cnt_nxt[c]   = LOCK_INIT;
                w_outen_nxt[c] = 1'b0;
`ifdef PAINTER_CLKEN_ALIGN_EN
                w_phase_nxt[c] = cfg_phase;
`endif
            end
        end
    end

    // Outputs: lock follows the next-state count so it rises on the 1->0 edge.
    always_comb begin
        w_ch_locked_nxt = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            w_ch_locked_nxt[c] = (w_cnt_nxt[c] == '0);
        end
    end

    assign outen     = r_outen;
    assign ch_locked = r_ch_locked;
    assign locked    = r_locked;
    assign cfg_ready = r_cfg_ready;
    assign cfg_err   = r_cfg_err;

endmodule

// File: tb/tb_painter_clken_gen.sv
// tb/tb_painter_clken_gen.sv - directed self-checking bench for painter_clken_gen
// Uses NUM_CH=3 so an out-of-range channel index is representable.
module tb_painter_clken_gen;

    localparam int NUM_CH = 3;
    localparam int ACC_W  = 32;
    localparam int LOCK   = 16;
    localparam int CH_W   = 2;

    logic              refclk = 1'b0;
    logic              rst;
    logic              cfg_valid;
    logic              cfg_ready;
    logic [CH_W-1:0]   cfg_ch;
    logic [ACC_W-1:0]  cfg_inc;
    logic [ACC_W-1:0]  cfg_phase;
    logic              cfg_err;
    logic [NUM_CH-1:0] outen;
    logic [NUM_CH-1:0] ch_locked;
    logic              locked;
`ifdef PAINTER_CLKEN_ALIGN_EN
    logic              align;
`endif

    painter_clken_gen #(.NUM_CH(NUM_CH), .ACC_W(ACC_W), .LOCK_CYCLES(LOCK)) dut (
        .refclk    (refclk),
        .rst       (rst),
`ifdef PAINTER_CLKEN_ALIGN_EN
        .align     (align),
`endif
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_ch    (cfg_ch),
        .cfg_inc   (cfg_inc),
        .cfg_phase (cfg_phase),
        .cfg_err   (cfg_err),
        .outen     (outen),
        .ch_locked (ch_locked),
        .locked    (locked)
    );

    always #5 refclk = ~refclk;

    int   n_checks = 0;
    int   n_errors = 0;
    logic mon0 = 1'b0;
    logic prev0 = 1'b0;
    logic mon1 = 1'b0;
    int   gap1 = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ch0 alternates every cycle, ch1 pulses every 4th cycle once monitored.
    task automatic tick();
        logic e0;
        logic e1;
        @(posedge refclk);
        #1;
        if (mon0) begin
            e0 = ~prev0;
            check("ch0_alt", outen[0], e0);
            prev0 = e0;
        end
        if (mon1) begin
            e1 = (gap1 == 3);
            check("ch1_period", outen[1], e1);
            gap1 = e1 ? 0 : gap1 + 1;
        end
    endtask

    task automatic write_cfg(input logic [CH_W-1:0] ch, input logic [31:0] inc, input logic [31:0] ph);
        cfg_valid = 1'b1;
        cfg_ch    = ch;
        cfg_inc   = inc;
        cfg_phase = ph;
        tick();
        cfg_valid = 1'b0;
    endtask

    initial begin
        int          cnt;
        logic [7:0]  v;
        logic        x;

        rst = 1'b1; cfg_valid = 1'b0; cfg_ch = '0; cfg_inc = '0; cfg_phase = '0;
`ifdef PAINTER_CLKEN_ALIGN_EN
        align = 1'b0;
`endif
        // 1: reset and release
        repeat (3) tick();
        check("rst_ready", cfg_ready, 1'b0);
        check("rst_locked", locked, 1'b0);
        check("rst_ch_locked", ch_locked, 3'b000);
        check("rst_outen", outen, 3'b000);
        rst = 1'b0;
        cnt = 0;
        for (int i = 1; i <= LOCK; i++) begin
            tick();
            if (outen != 0) cnt++;
            if (i == 1)  check("ready_after_rst", cfg_ready, 1'b1);
            if (i == 15) check("settle15_ch", ch_locked, 3'b000);
            if (i == 15) check("settle15_all", locked, 1'b0);
            if (i == 16) check("lock16_ch", ch_locked, 3'b111);
            if (i == 16) check("lock16_all", locked, 1'b1);
        end
        repeat (4) begin tick(); if (outen != 0) cnt++; end
        check("idle_no_pulse", cnt, 0);

        // 2: ch0 half rate
        write_cfg(2'd0, 32'h8000_0000, 32'h0);
        check("wr0_unlock", ch_locked, 3'b110);
        check("wr0_locked", locked, 1'b0);
        cnt = 0;
        for (int k = 1; k <= 24; k++) begin
            tick();
            if (k <= 16 && outen[0]) cnt++;
            if (k == 15) check("ch0_lock15", ch_locked[0], 1'b0);
            if (k == 16) check("ch0_lock16", ch_locked[0], 1'b1);
            if (k >= 17) v[k-17] = outen[0];
        end
        check("ch0_settle_quiet", cnt, 0);
        check("ch0_pattern", v, 8'b1010_1010);
        prev0 = v[7];
        mon0  = 1'b1;

        // 3: ch1 quarter rate with a restart mid-settle
        write_cfg(2'd1, 32'h4000_0000, 32'hC000_0000);
        repeat (7) tick();
        check("ch1_settling", ch_locked[1], 1'b0);
        write_cfg(2'd1, 32'h4000_0000, 32'hC000_0000);
        cnt = 0;
        for (int k = 1; k <= 24; k++) begin
            tick();
            if (k <= 16 && outen[1]) cnt++;
            if (k == 15) check("ch1_lock15", ch_locked[1], 1'b0);
            if (k == 16) check("ch1_lock16", ch_locked[1], 1'b1);
            if (k >= 17) v[k-17] = outen[1];
        end
        check("ch1_settle_quiet", cnt, 0);
        check("ch1_pattern", v, 8'b0001_0001);
        gap1 = 3;
        mon1 = 1'b1;

        // 4: out-of-range channel
        check("err_idle", cfg_err, 1'b0);
        write_cfg(2'd3, 32'hFFFF_FFFF, 32'h1234_5678);
        check("err_pulse", cfg_err, 1'b1);
        check("err_ch_locked", ch_locked, 3'b111);
        check("err_ch2_quiet", outen[2], 1'b0);
        tick();
        check("err_single", cfg_err, 1'b0);
        repeat (8) tick();

        // 5: long-run rate accuracy then mid-run reset
        write_cfg(2'd2, 32'h5555_5555, 32'h0);
        for (int k = 1; k <= LOCK; k++) begin
            tick();
            if (k == 15) check("ch2_lock15", locked, 1'b0);
            if (k == 16) check("ch2_lock16", locked, 1'b1);
        end
        cnt = 0;
        repeat (3000) begin tick(); if (outen[2]) cnt++; end
        check("ch2_rate", cnt, 999);
        mon0 = 1'b0;
        mon1 = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_mid_outen", outen, 3'b000);
        check("rst_mid_locked", locked, 1'b0);
        check("rst_mid_ready", cfg_ready, 1'b0);
        cnt = 0;
        for (int k = 1; k <= LOCK + 8; k++) begin
            tick();
            if (outen != 0) cnt++;
            if (k == 15) check("reset_lock15", locked, 1'b0);
            if (k == 16) check("reset_lock16", locked, 1'b1);
        end
        check("reset_inc_cleared", cnt, 0);

`ifdef PAINTER_CLKEN_ALIGN_EN
        // 6: realign two anti-phase channels
        write_cfg(2'd0, 32'h8000_0000, 32'h0);
        write_cfg(2'd1, 32'h8000_0000, 32'h0);
        repeat (LOCK) tick();
        for (int k = 0; k < 2; k++) begin
            tick();
            x = outen[0] ^ outen[1];
            check("anti_phase", x, 1'b1);
        end
        align = 1'b1;
        tick();
        align = 1'b0;
        check("align_edge", outen[1:0], 2'b00);
        tick();
        check("align_p1", outen[1:0], 2'b00);
        tick();
        check("align_p2", outen[1:0], 2'b11);
        tick();
        check("align_p3", outen[1:0], 2'b00);
        tick();
        check("align_p4", outen[1:0], 2'b11);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
